// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the FIFO read port, the stream reader and the downstream consumer.
interface fifo_stream_reader_if #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned POINTER_WIDTH = 5
);
  logic                     fifo_empty;
  logic [POINTER_WIDTH:0]   fifo_count;
  logic [WIDTH-1:0]         fifo_rdata;
  logic                     fifo_read_en;
  logic                     m_valid;
  logic [WIDTH-1:0]         m_data;
  logic                     m_ready;

  modport master (
    input  fifo_empty, fifo_count, fifo_rdata, m_ready,
    output fifo_read_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_count, fifo_rdata, m_ready,
    input  fifo_read_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Pops a synchronous FIFO (1-cycle read latency) into a 3-entry skid queue and
// re-presents the words on a valid/ready stream at one word per cycle.
module fifo_stream_reader #(
  parameter int unsigned DEPTH         = 32,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned POINTER_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  fifo_stream_reader_if.master bus,
  output logic                 busy,
  output logic [15:0]          words_out
);

  localparam int unsigned NENT     = 3;
  localparam logic [1:0]  PTR_LAST = 2'd2;

  logic [1:0]       r_occ;
  logic             r_inflight;
  logic [1:0]       r_rd_ptr;
  logic [1:0]       r_wr_ptr;
  logic [WIDTH-1:0] r_buf [NENT];
  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_data;
  logic             r_busy;
  logic [15:0]      r_words_out;

  logic             w_read_en;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_occ_nxt;
  logic [1:0]       w_rd_nxt;
  logic [1:0]       w_wr_nxt;
  logic [2:0]       w_credit_used;
  logic             w_unused;

  // fifo_count is for monitoring only
  assign w_unused = ^bus.fifo_count;

  // Credits cover both stored words and the word still on its way out of the FIFO
  assign w_credit_used = 3'({1'b0, r_occ}) + 3'({2'b00, r_inflight});
  assign w_read_en     = !reset && !bus.fifo_empty && enable && (w_credit_used < 3'(NENT));
  assign w_push        = r_inflight;
  assign w_pop         = (r_occ != 2'd0) && bus.m_ready;

  always_comb begin
    w_occ_nxt = r_occ;
    w_rd_nxt  = r_rd_ptr;
    w_wr_nxt  = r_wr_ptr;
    if (w_push && !w_pop) begin
      w_occ_nxt = r_occ + 2'd1;
    end else if (!w_push && w_pop) begin
      w_occ_nxt = r_occ - 2'd1;
    end
    if (w_pop) begin
      w_rd_nxt = (r_rd_ptr == PTR_LAST) ? 2'd0 : r_rd_ptr + 2'd1;
    end
    if (w_push) begin
      w_wr_nxt = (r_wr_ptr == PTR_LAST) ? 2'd0 : r_wr_ptr + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ       <= 2'd0;
      r_inflight  <= 1'b0;
      r_rd_ptr    <= 2'd0;
      r_wr_ptr    <= 2'd0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_busy      <= 1'b0;
      r_words_out <= 16'd0;
      for (int i = 0; i < NENT; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_occ      <= w_occ_nxt;
      r_inflight <= w_read_en;
      r_rd_ptr   <= w_rd_nxt;
      r_wr_ptr   <= w_wr_nxt;
      if (w_push) begin
        r_buf[r_wr_ptr] <= bus.fifo_rdata;
      end
      // Next head is the word being captured only when the queue is otherwise empty
      if (w_push && (r_wr_ptr == w_rd_nxt)) begin
        r_m_data <= bus.fifo_rdata;
      end else begin
        r_m_data <= r_buf[w_rd_nxt];
      end
      r_m_valid <= (w_occ_nxt != 2'd0);
      r_busy    <= (w_occ_nxt != 2'd0) || w_read_en;
      if (w_pop) begin
        r_words_out <= r_words_out + 16'd1;
      end
    end
  end

  assign bus.fifo_read_en = w_read_en;
  assign bus.m_valid      = r_m_valid;
  assign bus.m_data       = r_m_data;
  assign busy             = r_busy;
  assign words_out        = r_words_out;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO and an in-order scoreboard.
module tb_fifo_stream_reader;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned PW    = 5;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        m_ready;
  logic        push;
  logic [7:0]  push_data;
  logic        link_rst;
  logic        busy;
  logic [15:0] words_out;

  logic [7:0]  fq [$];
  int          fcnt;
  logic [7:0]  f_rdata;
  logic        f_unf;
  logic        f_ovf;

  logic [7:0]  exp_q [$];
  int          exp_words;
  int          n_reads;
  int          n_vec;
  int          n_err;
  int          pushed;

  fifo_stream_reader_if #(.WIDTH(WIDTH), .POINTER_WIDTH(PW)) bus ();

  fifo_stream_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus),
    .busy      (busy),
    .words_out (words_out)
  );

  assign bus.fifo_empty = (fcnt == 0);
  assign bus.fifo_count = 6'(fcnt);
  assign bus.fifo_rdata = f_rdata;
  assign bus.m_ready    = m_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous FIFO: data appears the cycle after a pop
  initial begin
    fcnt    = 0;
    f_rdata = 8'h00;
    f_unf   = 1'b0;
    f_ovf   = 1'b0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset && link_rst) begin
      fq.delete();
      fcnt    = 0;
      f_rdata <= 8'h00;
    end else if (!reset || !link_rst) begin
      if (bus.fifo_read_en) begin
        if (fq.size() == 0) f_unf = 1'b1;
        else                f_rdata <= fq.pop_front();
      end
      if (push) begin
        fq.push_back(push_data);
        if (fq.size() > DEPTH) f_ovf = 1'b1;
      end
      fcnt = fq.size();
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: settle inputs, score the transfer at the coming edge, end at the next negedge
  task automatic step();
    #1;
    if (push) exp_q.push_back(push_data);
    check("rd_while_empty", 32'(bus.fifo_read_en && bus.fifo_empty), 32'd0);
    if (bus.fifo_read_en) n_reads++;
    if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) check("sb_underrun", 32'(bus.m_valid), 32'd0);
      else                   check("sb_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
      exp_words++;
    end
    @(posedge clk);
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] d);
    push      = 1'b1;
    push_data = d;
    step();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; m_ready = 1'b0;
    push = 1'b0; push_data = 8'h00; link_rst = 1'b0;
    exp_words = 0; n_reads = 0; n_vec = 0; n_err = 0; pushed = 0;

    // Reset held with a non-empty FIFO and enable high
    @(negedge clk);
    push_word(8'h5A);
    check("rst_fifo_nonempty", 32'(bus.fifo_empty), 32'd0);
    check("rst_read_en", 32'(bus.fifo_read_en), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_words_out", 32'(words_out), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    reset = 1'b0; link_rst = 1'b1;
    #1;
    check("rel_read_en", 32'(bus.fifo_read_en), 32'd1);
    m_ready = 1'b1;
    step();
    check("t1_lat1_valid", 32'(bus.m_valid), 32'd0);
    step();
    check("t1_lat2_valid", 32'(bus.m_valid), 32'd1);
    step();
    check("t1_words_out", 32'(words_out), 32'(exp_words));

    // 32-word burst with m_ready held high
    enable = 1'b0;
    for (int i = 1; i <= 32; i++) push_word(8'(i));
    check("t2_fifo_full", 32'(bus.fifo_count), 32'd32);
    enable = 1'b1;
    #1;
    check("t2_first_rd", 32'(bus.fifo_read_en), 32'd1);
    check("t2_c0_valid", 32'(bus.m_valid), 32'd0);
    step();
    check("t2_c1_valid", 32'(bus.m_valid), 32'd0);
    step();
    for (int i = 0; i < 32; i++) begin
      check("t2_stream_valid", 32'(bus.m_valid), 32'd1);
      step();
    end
    check("t2_end_valid", 32'(bus.m_valid), 32'd0);
    check("t2_words_out", 32'(words_out), 32'd33);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Back-pressure: only three credits may be taken
    enable = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(8'h40 + 8'(i));
    enable = 1'b1; n_reads = 0;
    repeat (8) step();
    check("t3_read_pulses", 32'(n_reads), 32'd3);
    check("t3_m_valid", 32'(bus.m_valid), 32'd1);
    check("t3_m_data_held", 32'(bus.m_data), 32'h40);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_fifo_left", 32'(bus.fifo_count), 32'd7);
    m_ready = 1'b1;
    drain(40);
    check("t3_words_out", 32'(words_out), 32'd43);

    // enable dropped right after one read issues
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push_word(8'h60 + 8'(i));
    enable = 1'b1;
    #1;
    check("t4_read_issued", 32'(bus.fifo_read_en), 32'd1);
    step();
    enable = 1'b0;
    #1;
    check("t4_read_stopped", 32'(bus.fifo_read_en), 32'd0);
    check("t4_busy_inflight", 32'(busy), 32'd1);
    n_reads = 0;
    repeat (4) step();
    check("t4_no_more_reads", 32'(n_reads), 32'd0);
    check("t4_busy_fall", 32'(busy), 32'd0);
    check("t4_left_in_fifo", 32'(bus.fifo_count), 32'd2);
    check("t4_words_out", 32'(words_out), 32'd44);
    enable = 1'b1;
    drain(20);

    // Random back-pressure over 1000 words with concurrent FIFO writes
    pushed = 0;
    for (int c = 0; c < 20000 && (pushed < 1000 || exp_q.size() > 0); c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (pushed < 1000 && fcnt < DEPTH && $urandom_range(0, 3) != 0) begin
        push      = 1'b1;
        push_data = 8'(pushed * 7 + 3);
        pushed++;
      end
      step();
    end
    check("t5_pushed", 32'(pushed), 32'd1000);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t5_words_out", 32'(words_out), 32'd1046);

    // Async reset with two buffered words and one in flight
    m_ready = 1'b0; enable = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'h80 + 8'(i));
    enable = 1'b1;
    repeat (3) step();
    check("t6_pre_valid", 32'(bus.m_valid), 32'd1);
    check("t6_pre_busy", 32'(busy), 32'd1);
    check("t6_pre_fifo", 32'(bus.fifo_count), 32'd2);
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(bus.m_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_words", 32'(words_out), 32'd0);
    check("t6_rst_read_en", 32'(bus.fifo_read_en), 32'd0);
    exp_q.delete();
    exp_words = 0;
    step();
    step();
    reset = 1'b0; m_ready = 1'b1;
    repeat (4) step();
    check("t6_no_stale_valid", 32'(bus.m_valid), 32'd0);
    check("t6_idle_busy", 32'(busy), 32'd0);
    push_word(8'h90);
    push_word(8'h91);
    drain(20);
    check("t6_words_out", 32'(words_out), 32'd2);

    check("fifo_underflow", 32'(f_unf), 32'd0);
    check("fifo_overflow", 32'(f_ovf), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
